vga_pixel_fetch: RTL and testbench
==================================

VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
REQ-001 SHALL have parameter BRAM_LATENCY, default 2, framebuffer read latency in cycles (1..4).
REQ-002 SHALL have parameter PIXEL_W, default 12, RGB word width (4:4:4).
REQ-003 clk  in  1  pixel clock; single clock domain.
REQ-004 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-005 hcount  in  10  pixel number on line, from timing generator.
REQ-006 vcount  in  10  line number, from timing generator.
REQ-007 hsync_i, vsync_i, de_i  in  1 each  timing-generator sync and display-area flags (active-high).
REQ-008 fb_addr  out  17  framebuffer read address within selected buffer.
REQ-009 fb_buf  out  1  framebuffer bank being read (displayed bank).
REQ-010 fb_rd_en  out  1  read enable.
REQ-011 fb_data  in  PIXEL_W  read data, valid BRAM_LATENCY cycles after fb_rd_en.
REQ-012 swap_req  in  1  one-cycle pulse from writer: back buffer complete.
REQ-013 swap_ack  out  1  one-cycle pulse: bank swap performed.
REQ-014 rgb  out  PIXEL_W  pixel to DAC.
REQ-015 hsync_o, vsync_o, de_o  out  1 each  sync/enable aligned with rgb.

Function
REQ-016 Display window: hcount 144..783, vcount 35..514; x = hcount-144, y = vcount-35.
REQ-017 Source image 320x240, doubled in both axes: fb_addr = (y>>1)*320 + (x>>1), computed with >=17-bit intermediates, registered (1 cycle).
REQ-018 fb_rd_en SHALL be the registered de_i; fb_addr SHALL be 0 when de_i low.
REQ-019 Total latency hcount/vcount -> rgb SHALL be 1+BRAM_LATENCY cycles; hsync_o, vsync_o, de_o SHALL be hsync_i, vsync_i, de_i delayed by the same count.
REQ-020 rgb SHALL be fb_data when delayed de is high, else 0.
REQ-021 Swap FSM states IDLE, PENDING; IDLE->PENDING on swap_req; PENDING->IDLE on vsync_i rising edge (vsync_i high, previous sample low).
REQ-022 On that edge: fb_buf toggles, swap_ack pulses one cycle.
REQ-023 swap_req coincident with the vsync edge while IDLE SHALL swap on that edge (no frame lost).
REQ-024 Repeated swap_req while PENDING coalesce into one swap.
REQ-025 fb_buf SHALL never change outside the vsync rising-edge cycle (no tearing).

Reset
REQ-026 While rst_n low: rgb, fb_addr, fb_rd_en, fb_buf, swap_ack, hsync_o, vsync_o, de_o all 0; FSM IDLE; delay lines and vsync edge register cleared.
REQ-027 Reset mid-frame SHALL discard pending swap; outputs return to aligned operation within 1+BRAM_LATENCY cycles of release.

Configuration
REQ-028 Macro VGA_TEST_PATTERN_EN: when defined, adds input pattern_sel (1 bit); pattern_sel high replaces rgb in display area with 8 vertical colour bars, each 80 px wide, bar index = x/80, colour bits {i[2],i[1],i[0]} each expanded to 4-bit 0xF/0x0; latency unchanged.
REQ-029 Without VGA_TEST_PATTERN_EN, pattern_sel port and logic SHALL be absent; rgb always from fb_data.

Structure
REQ-030 Shared package vga_pkg: H_OFFSET=144, V_OFFSET=35, FRAME_WIDTH=640, FRAME_HEIGHT=480, SRC_WIDTH=320, SRC_HEIGHT=240, FB_ADDR_W=17; swap FSM state enum.
REQ-031 One sub-module vga_delay_line (parameters WIDTH, DEPTH; async active-low reset to 0) SHALL implement all sync/flag/pattern alignment.

Verification
REQ-032 hcount=144, vcount=35, de_i=1 -> fb_addr=0, fb_rd_en=1 one cycle later; hcount=783, vcount=514 -> fb_addr=76799.
REQ-033 hcount=146, vcount=37 -> fb_addr=321; fb_data=0xABC returned at latency -> rgb=0xABC exactly 3 cycles (BRAM_LATENCY=2) after input, de_o high same cycle.
REQ-034 de_i=0, fb_data=0xFFF -> rgb=0x000; hsync_o equals hsync_i delayed 3 cycles across full 800x525 frame.
REQ-035 swap_req mid-frame -> fb_buf 0->1 and swap_ack pulse only on next vsync_i rising edge; three reqs in one frame -> single toggle; req on edge cycle -> swap on that edge.
REQ-036 rst_n low while PENDING -> all outputs 0, no swap at next vsync; with VGA_TEST_PATTERN_EN and pattern_sel=1, x=80..159 -> rgb=0x00F.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, swap FSM state type and address/bar helpers for the VGA pixel fetch path.
package vga_pkg;

  localparam int H_OFFSET     = 144;
  localparam int V_OFFSET     = 35;
  localparam int FRAME_WIDTH  = 640;
  localparam int FRAME_HEIGHT = 480;
  localparam int SRC_WIDTH    = 320;
  localparam int SRC_HEIGHT   = 240;
  localparam int FB_ADDR_W    = 17;

  typedef enum logic [0:0] {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_e;

  // 2x2 pixel doubling: each source pixel covers two screen columns and two screen lines.
  function automatic logic [FB_ADDR_W-1:0] fb_addr_of(input logic [9:0] hc,
                                                      input logic [9:0] vc);
    logic [FB_ADDR_W-1:0] x;
    logic [FB_ADDR_W-1:0] y;
    x = FB_ADDR_W'(hc) - FB_ADDR_W'(H_OFFSET);
    y = FB_ADDR_W'(vc) - FB_ADDR_W'(V_OFFSET);
    return (y >> 1) * FB_ADDR_W'(SRC_WIDTH) + (x >> 1);
  endfunction

  function automatic logic [2:0] bar_index(input logic [9:0] hc);
    logic [9:0] x;
    x = hc - 10'(H_OFFSET);
    return 3'(x / 10'd80);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register used to keep sync/flag side-band bits aligned with pixel data.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Framebuffer pixel fetch for 640x480 VGA from a double-buffered 320x240 source, with vsync-locked bank swap.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN (adds pattern_sel input).
module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter int BRAM_LATENCY = 2,
  parameter int PIXEL_W      = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           hcount,
  input  logic [9:0]           vcount,
  input  logic                 hsync_i,
  input  logic                 vsync_i,
  input  logic                 de_i,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                 pattern_sel,
`endif
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic                 fb_buf,
  output logic                 fb_rd_en,
  input  logic [PIXEL_W-1:0]   fb_data,
  input  logic                 swap_req,
  output logic                 swap_ack,
  output logic [PIXEL_W-1:0]   rgb,
  output logic                 hsync_o,
  output logic                 vsync_o,
  output logic                 de_o,
  output swap_state_e          o_dbg_state
);

  localparam int PIPE_DEPTH = 1 + BRAM_LATENCY;
`ifdef VGA_TEST_PATTERN_EN
  localparam int DL_W = 7;
`else
  localparam int DL_W = 3;
`endif

  logic [FB_ADDR_W-1:0] r_fb_addr;
  logic                 r_fb_rd_en;
  logic                 r_fb_buf;
  logic                 r_swap_ack;
  logic                 r_vsync_prev;
  swap_state_e          r_state;
  swap_state_e          w_state_nxt;
  logic                 w_do_swap;
  logic                 w_vs_rise;
  logic [DL_W-1:0]      w_dl_d;
  logic [DL_W-1:0]      w_dl_q;
  logic                 w_hs_dly;
  logic                 w_vs_dly;
  logic                 w_de_dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fb_addr  <= '0;
      r_fb_rd_en <= 1'b0;
    end else begin
      r_fb_addr  <= de_i ? fb_addr_of(hcount, vcount) : '0;
      r_fb_rd_en <= de_i;
    end
  end

  assign fb_addr  = r_fb_addr;
  assign fb_rd_en = r_fb_rd_en;

  // Side-band bits ride the same depth as address register + BRAM read so they meet fb_data.
`ifdef VGA_TEST_PATTERN_EN
  logic       w_pat_dly;
  logic [2:0] w_bar_dly;
  assign w_dl_d = {pattern_sel, bar_index(hcount), hsync_i, vsync_i, de_i};
  assign {w_pat_dly, w_bar_dly, w_hs_dly, w_vs_dly, w_de_dly} = w_dl_q;
`else
  assign w_dl_d = {hsync_i, vsync_i, de_i};
  assign {w_hs_dly, w_vs_dly, w_de_dly} = w_dl_q;
`endif

  vga_delay_line #(
    .WIDTH (DL_W),
    .DEPTH (PIPE_DEPTH)
  ) u_align (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (w_dl_d),
    .o_q   (w_dl_q)
  );

  assign hsync_o = w_hs_dly;
  assign vsync_o = w_vs_dly;
  assign de_o    = w_de_dly;

  always_comb begin
    rgb = '0;
    if (w_de_dly) rgb = fb_data;
`ifdef VGA_TEST_PATTERN_EN
    if (w_de_dly && w_pat_dly)
      rgb = PIXEL_W'({{4{w_bar_dly[2]}}, {4{w_bar_dly[1]}}, {4{w_bar_dly[0]}}});
`endif
  end

  // Handshake: swap_req is a one-cycle pulse (no ready); swap_ack is a one-cycle pulse in the
  // cycle after the vsync rising edge that applied the swap, the same cycle fb_buf shows the new bank.
  assign w_vs_rise = vsync_i & ~r_vsync_prev;

  always_comb begin
    w_state_nxt = r_state;
    w_do_swap   = 1'b0;
    case (r_state)
      SWAP_IDLE: begin
        if (swap_req) begin
          if (w_vs_rise) w_do_swap = 1'b1;
          else           w_state_nxt = SWAP_PENDING;
        end
      end
      SWAP_PENDING: begin
        if (w_vs_rise) begin
          w_do_swap   = 1'b1;
          w_state_nxt = SWAP_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= SWAP_IDLE;
      r_vsync_prev <= 1'b0;
      r_fb_buf     <= 1'b0;
      r_swap_ack   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_vsync_prev <= vsync_i;
      r_fb_buf     <= r_fb_buf ^ w_do_swap;
      r_swap_ack   <= w_do_swap;
    end
  end

  assign fb_buf      = r_fb_buf;
  assign swap_ack    = r_swap_ack;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Scoreboard bench for vga_pixel_fetch: random timing/swap stimulus against a frame-level model.
module tb_vga_pixel_fetch;
  import vga_pkg::*;

  localparam int L    = 2;
  localparam int PIPE = 1 + L;
  localparam int PW   = 12;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [9:0]  hcount = '0, vcount = '0;
  logic        hsync_i = 0, vsync_i = 0, de_i = 0, swap_req = 0;
  logic [16:0] fb_addr;
  logic        fb_buf, fb_rd_en, swap_ack, hsync_o, vsync_o, de_o;
  logic [PW-1:0] fb_data, rgb;
  swap_state_e dbg_state;
`ifdef VGA_TEST_PATTERN_EN
  logic        pattern_sel = 0;
`endif

  vga_pixel_fetch #(.BRAM_LATENCY(L), .PIXEL_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .de_i(de_i),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .fb_addr(fb_addr), .fb_buf(fb_buf), .fb_rd_en(fb_rd_en), .fb_data(fb_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .rgb(rgb),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o), .o_dbg_state(dbg_state)
  );

  // framebuffer contents: deterministic per bank/address, 0xABC planted at bank 0 addr 321
  function automatic logic [PW-1:0] mem_val(input bit b, input int addr);
    if (!b && addr == 321) return 12'hABC;
    return 12'((addr * 29 + (b ? 1713 : 0)) % 4096);
  endfunction

  // BRAM stand-in: data L cycles after the read request, 0xFFF when not reading
  logic [PW-1:0] bram_pipe [L];
  always @(posedge clk) begin
    bram_pipe[0] <= fb_rd_en ? mem_val(fb_buf, int'(fb_addr)) : 12'hFFF;
    for (int i = 1; i < L; i++) bram_pipe[i] <= bram_pipe[i-1];
  end
  assign fb_data = bram_pipe[L-1];

  // reference model state
  bit m_buf = 0, m_pending = 0, m_prev_vs = 0;

  function automatic logic [16:0] spec_addr(input int hc, input int vc);
    int x, y;
    x = hc - 144;
    y = vc - 35;
    return 17'((y / 2) * 320 + x / 2);
  endfunction

  // scoreboard queues: {due_cycle, expected}
  logic [52:0] addr_q[$];   // due[52:21], addr[20:4], rd_en, buf, ack, pending
  logic [46:0] pix_q[$];    // due[46:15], rgb[14:3], hs, vs, de
  int checks = 0;
  int errors = 0;

  task automatic push_zero_pix(input int unsigned due);
    pix_q.push_back({due, 12'h000, 3'b000});
  endtask

  task automatic drive_cycle(input int hc, input int vc, input bit hs, input bit vs,
                             input bit de, input bit req, input bit pat);
    bit rise, ack;
    logic [16:0] ea;
    logic [PW-1:0] er;
    int bar;
    @(posedge clk); #1;
    rst_n = 1; hcount = 10'(hc); vcount = 10'(vc);
    hsync_i = hs; vsync_i = vs; de_i = de; swap_req = req;
`ifdef VGA_TEST_PATTERN_EN
    pattern_sel = pat;
`endif
    rise = vs && !m_prev_vs;
    m_prev_vs = vs;
    ack = 0;
    if (rise && (m_pending || req)) begin
      m_buf = !m_buf; m_pending = 0; ack = 1;
    end else if (req) begin
      m_pending = 1;
    end
    ea = de ? spec_addr(hc, vc) : 17'd0;
    addr_q.push_back({cyc + 1, ea, de, m_buf, ack, m_pending});
    er = de ? mem_val(m_buf, int'(ea)) : 12'h000;
`ifdef VGA_TEST_PATTERN_EN
    if (de && pat) begin
      bar = (hc - 144) / 80;
      er = 12'(((bar & 4) != 0 ? 12'hF00 : 0) | ((bar & 2) != 0 ? 12'h0F0 : 0) |
               ((bar & 1) != 0 ? 12'h00F : 0));
    end
`else
    bar = pat ? 1 : 0;
    if (bar < 0) er = 0;
`endif
    pix_q.push_back({cyc + PIPE, er, hs, vs, de});
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst_n = 0; hcount = 0; vcount = 0; hsync_i = 0; vsync_i = 0; de_i = 0; swap_req = 0;
    pix_q.delete(); addr_q.delete();
    m_buf = 0; m_pending = 0; m_prev_vs = 0;
    for (int d = 0; d < PIPE; d++) push_zero_pix(cyc + d);
    addr_q.push_back({cyc, 21'd0});
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      push_zero_pix(cyc + PIPE);
      addr_q.push_back({cyc + 1, 21'd0});
    end
  endtask

  // in-window pixel with random position; used by the swap scenarios
  task automatic step(input bit vs, input bit req);
    drive_cycle($urandom_range(144, 783), $urandom_range(35, 514),
                1'($urandom_range(0, 1)), vs, 1'b1, req, 1'b0);
  endtask

  // monitor: pops whenever an expected entry falls due
  logic [52:0] ae;
  logic [46:0] pe;
  always @(negedge clk) begin
    while (addr_q.size() > 0 && addr_q[0][52:21] <= cyc) begin
      ae = addr_q.pop_front();
      checks++;
      if (ae[52:21] != cyc ||
          {fb_addr, fb_rd_en, fb_buf, swap_ack, dbg_state == SWAP_PENDING} !== ae[20:0]) begin
        errors++;
        $display("FAIL addr_swap cyc=%0d got addr=%0d rd=%b buf=%b ack=%b pend=%b exp addr=%0d rd=%b buf=%b ack=%b pend=%b",
                 cyc, fb_addr, fb_rd_en, fb_buf, swap_ack, dbg_state == SWAP_PENDING,
                 ae[20:4], ae[3], ae[2], ae[1], ae[0]);
      end
    end
    while (pix_q.size() > 0 && pix_q[0][46:15] <= cyc) begin
      pe = pix_q.pop_front();
      checks++;
      if (pe[46:15] != cyc || {rgb, hsync_o, vsync_o, de_o} !== pe[14:0]) begin
        errors++;
        $display("FAIL pixel cyc=%0d got rgb=%h hs=%b vs=%b de=%b exp rgb=%h hs=%b vs=%b de=%b",
                 cyc, rgb, hsync_o, vsync_o, de_o, pe[14:3], pe[2], pe[1], pe[0]);
      end
    end
  end

  initial begin
    int hc, vc;
    bit win;
    do_reset(3);

    // directed address / data / blanking points
    drive_cycle(144, 35, 0, 0, 1, 0, 0);
    drive_cycle(783, 514, 1, 0, 1, 0, 0);
    drive_cycle(146, 37, 0, 0, 1, 0, 0);
    drive_cycle(200, 100, 1, 0, 0, 0, 0);
    drive_cycle(10, 2, 0, 1, 0, 0, 0);
    drive_cycle(10, 2, 0, 0, 0, 0, 0);

    // swap: mid-frame request, then three requests in one frame -> one toggle each edge
    repeat (4) step(0, 0);
    step(0, 1);
    repeat (5) step(0, 0);
    step(1, 0);
    repeat (3) step(1, 0);
    step(0, 1); step(0, 0); step(0, 1); step(0, 1);
    repeat (3) step(0, 0);
    step(1, 0);
    step(0, 0);
    // request on the edge cycle itself
    step(1, 1);
    repeat (3) step(1, 0);
    step(0, 0);

    // reset while pending discards the swap
    step(0, 1);
    step(0, 0);
    do_reset(4);
    step(0, 0);
    step(1, 0);
    repeat (4) step(0, 0);

`ifdef VGA_TEST_PATTERN_EN
    drive_cycle(224, 40, 0, 0, 1, 0, 1);
    drive_cycle(303, 41, 0, 0, 1, 0, 1);
    drive_cycle(783, 42, 0, 0, 1, 0, 1);
`endif

    // random frame traffic
    for (int i = 0; i < 3000; i++) begin
      hc = $urandom_range(0, 799);
      vc = $urandom_range(0, 524);
      win = (hc >= 144 && hc <= 783 && vc >= 35 && vc <= 514);
      drive_cycle(hc, vc, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                  win && ($urandom_range(0, 7) != 0), $urandom_range(0, 9) == 0,
                  1'($urandom_range(0, 1)));
      if (i == 1500) do_reset(2);
    end

    repeat (PIPE + 3) @(posedge clk);
    checks++;
    if (addr_q.size() != 0 || pix_q.size() != 0) begin
      errors++;
      $display("FAIL drain got addr_q=%0d pix_q=%0d exp 0 0", addr_q.size(), pix_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
